// File: rtl/aes_uart_ctrl_pkg.sv
// aes_uart_pkg: shared constants and types for the AES UART command controller.
//   - opcode values of the UART command frames
//   - keylen_t encoding of the KeyLen output
//   - key_bytes(): payload length of a SET_KEY frame for a given key length
//   - default ack reply bytes
package aes_uart_pkg;

  localparam logic [7:0] OP_SET_KEYLEN = 8'h01;
  localparam logic [7:0] OP_SET_KEY    = 8'h02;
  localparam logic [7:0] OP_ENC        = 8'h10;
  localparam logic [7:0] OP_DEC        = 8'h11;

  localparam logic [7:0] ACK_OK_DEFAULT  = 8'hA5;
  localparam logic [7:0] ACK_ERR_DEFAULT = 8'hEE;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10
  } keylen_t;

  // Number of key bytes a SET_KEY frame carries for the given key length.
  function automatic logic [5:0] key_bytes(input keylen_t kl);
    case (kl)
      KL_192:  return 6'd24;
      KL_256:  return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/aes_uart_ctrl_if.sv
// my_axis_if: minimal AXI-stream style byte/block channel.
//   tdata  W-bit payload
//   tvalid source has data
//   tready sink accepts data (transfer on tvalid & tready)
//   tlast  marks the final beat of a frame
// Modports: master drives tdata/tvalid/tlast, slave drives tready.
interface my_axis_if #(parameter int W = 8);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aes_uart_ctrl_block_serializer.sv
// block_serializer: turns a 128-bit block into 16 bytes, MSB first.
//   Clk, Rst          clock, synchronous active-high reset
//   load, loadData    capture a new block (ignored bytes of a previous block are dropped)
//   tdata/tvalid/tlast/tready  byte stream out, tlast on byte 15
//   done              one-cycle strobe when the last byte is accepted
module block_serializer (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [127:0] loadData,
  output logic [7:0]   tdata,
  output logic         tvalid,
  output logic         tlast,
  input  logic         tready,
  output logic         done
);

  logic [127:0] shiftReg;
  logic [3:0]   byteIdx;
  logic         busy;

  assign tdata  = shiftReg[127:120];
  assign tvalid = busy;
  assign tlast  = busy && (byteIdx == 4'd15);
  assign done   = tvalid && tready && tlast;

  // Output byte only advances on a handshake, so tdata holds during a stall.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shiftReg <= '0;
      byteIdx  <= '0;
      busy     <= 1'b0;
    end else if (load) begin
      shiftReg <= loadData;
      byteIdx  <= '0;
      busy     <= 1'b1;
    end else if (tvalid && tready) begin
      shiftReg <= {shiftReg[119:0], 8'h00};
      byteIdx  <= byteIdx + 4'd1;
      if (byteIdx == 4'd15) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_uart_ctrl.sv
// aes_uart_ctrl: command-frame controller between UART byte streams and AES cores.
//   Clk, Rst        clock, synchronous active-high reset
//   s_axis          UART RX bytes (command frames)
//   m_axis          UART TX bytes (ack byte or 16-byte result block)
//   enc_axis/dec_axis          plaintext/ciphertext bytes forwarded to the cores
//   enc_res_axis/dec_res_axis  128-bit result blocks from the cores
//   Key, KeyLen     key configuration (key top-aligned, unused bytes zero)
//   KeyUpdate, KeyLenUpdate    one-cycle pulses after configuration changes
//   EncEn, DecEn    core enables, dropped for one cycle to flush a core
module aes_uart_ctrl
  import aes_uart_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] ACK_OK         = ACK_OK_DEFAULT,
  parameter logic [7:0] ACK_ERR        = ACK_ERR_DEFAULT
) (
  input  logic         Clk,
  input  logic         Rst,
  my_axis_if.slave     s_axis,
  my_axis_if.master    m_axis,
  my_axis_if.master    enc_axis,
  my_axis_if.slave     enc_res_axis,
  my_axis_if.master    dec_axis,
  my_axis_if.slave     dec_res_axis,
  output logic [255:0] Key,
  output logic [1:0]   KeyLen,
  output logic         KeyUpdate,
  output logic         KeyLenUpdate,
  output logic         EncEn,
  output logic         DecEn
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_KLEN = 3'd1;
  localparam logic [2:0] ST_KEY  = 3'd2;
  localparam logic [2:0] ST_FWD  = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_SEND = 3'd5;
  localparam logic [2:0] ST_ACK  = 3'd6;

  logic [2:0]    state;
  logic          isDec;
  logic [5:0]    byteCnt;
  logic [255:0]  keyStage;
  logic [255:0]  keyStageNext;
  logic [TW-1:0] idleCnt;
  logic [7:0]    ackByte;

  logic          rxHs;
  logic          inFrame;
  logic          timeout;
  logic          lastKeyByte;
  logic          resHs;
  logic [127:0]  resData;
  logic [7:0]    serData;
  logic          serValid;
  logic          serLast;
  logic          serReady;
  logic          serDone;
  logic          unusedTlast;

  assign unusedTlast = s_axis.tlast ^ enc_res_axis.tlast ^ dec_res_axis.tlast;

  assign rxHs        = s_axis.tvalid && s_axis.tready;
  assign inFrame     = (state == ST_KLEN) || (state == ST_KEY) || (state == ST_FWD);
  assign timeout     = inFrame && !rxHs && (idleCnt == TW'(TIMEOUT_CYCLES - 1));
  assign lastKeyByte = (byteCnt == key_bytes(keylen_t'(KeyLen)) - 6'd1);
  assign resHs       = isDec ? (dec_res_axis.tvalid && dec_res_axis.tready)
                             : (enc_res_axis.tvalid && enc_res_axis.tready);
  assign resData     = isDec ? dec_res_axis.tdata : enc_res_axis.tdata;
  assign serReady    = m_axis.tready && (state == ST_SEND);

  // Key bytes land in a staging copy so an aborted SET_KEY leaves Key untouched.
  always_comb begin
    keyStageNext = keyStage;
    keyStageNext[9'd255 - {byteCnt, 3'b000} -: 8] = s_axis.tdata;
  end

  // Stream routing; every valid/ready is forced low while Rst is asserted.
  always_comb begin
    s_axis.tready = 1'b0;
    case (state)
      ST_IDLE, ST_KLEN, ST_KEY: s_axis.tready = !Rst;
      ST_FWD:  s_axis.tready = !Rst && (isDec ? dec_axis.tready : enc_axis.tready);
      default: s_axis.tready = 1'b0;
    endcase

    enc_axis.tdata  = s_axis.tdata;
    enc_axis.tlast  = (byteCnt == 6'd15);
    enc_axis.tvalid = !Rst && (state == ST_FWD) && !isDec && s_axis.tvalid;
    dec_axis.tdata  = s_axis.tdata;
    dec_axis.tlast  = (byteCnt == 6'd15);
    dec_axis.tvalid = !Rst && (state == ST_FWD) && isDec && s_axis.tvalid;

    enc_res_axis.tready = !Rst && (state == ST_WAIT) && !isDec;
    dec_res_axis.tready = !Rst && (state == ST_WAIT) && isDec;

    if (state == ST_ACK) begin
      m_axis.tdata  = ackByte;
      m_axis.tvalid = !Rst;
      m_axis.tlast  = 1'b1;
    end else begin
      m_axis.tdata  = serData;
      m_axis.tvalid = !Rst && serValid;
      m_axis.tlast  = serLast;
    end
  end

  block_serializer uSer (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (resHs && (state == ST_WAIT)),
    .loadData (resData),
    .tdata    (serData),
    .tvalid   (serValid),
    .tlast    (serLast),
    .tready   (serReady),
    .done     (serDone)
  );

  // Frame FSM, configuration registers, inter-byte timeout and core flush.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= ST_IDLE;
      isDec        <= 1'b0;
      byteCnt      <= '0;
      keyStage     <= '0;
      idleCnt      <= '0;
      ackByte      <= '0;
      Key          <= '0;
      KeyLen       <= KL_128;
      KeyUpdate    <= 1'b0;
      KeyLenUpdate <= 1'b0;
      EncEn        <= 1'b0;
      DecEn        <= 1'b0;
    end else begin
      KeyUpdate    <= 1'b0;
      KeyLenUpdate <= 1'b0;
      EncEn        <= 1'b1;
      DecEn        <= 1'b1;

      if (rxHs || !inFrame) idleCnt <= '0;
      else                  idleCnt <= idleCnt + TW'(1);

      if (timeout) begin
        state   <= ST_ACK;
        ackByte <= ACK_ERR;
        if (state == ST_FWD) begin
          if (isDec) DecEn <= 1'b0;
          else       EncEn <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: if (rxHs) begin
            byteCnt  <= '0;
            keyStage <= '0;
            case (s_axis.tdata)
              OP_SET_KEYLEN: state <= ST_KLEN;
              OP_SET_KEY:    state <= ST_KEY;
              OP_ENC: begin state <= ST_FWD; isDec <= 1'b0; end
              OP_DEC: begin state <= ST_FWD; isDec <= 1'b1; end
              default: begin state <= ST_ACK; ackByte <= ACK_ERR; end
            endcase
          end
          ST_KLEN: if (rxHs) begin
            state <= ST_ACK;
            if (s_axis.tdata[1:0] != 2'b11) begin
              KeyLen       <= s_axis.tdata[1:0];
              KeyLenUpdate <= 1'b1;
              ackByte      <= ACK_OK;
            end else begin
              ackByte <= ACK_ERR;
            end
          end
          ST_KEY: if (rxHs) begin
            keyStage <= keyStageNext;
            byteCnt  <= byteCnt + 6'd1;
            if (lastKeyByte) begin
              Key       <= keyStageNext;
              KeyUpdate <= 1'b1;
              ackByte   <= ACK_OK;
              state     <= ST_ACK;
            end
          end
          ST_FWD: if (rxHs) begin
            byteCnt <= byteCnt + 6'd1;
            if (byteCnt == 6'd15) state <= ST_WAIT;
          end
          ST_WAIT: if (resHs) state <= ST_SEND;
          ST_SEND: if (serDone) state <= ST_IDLE;
          ST_ACK:  if (m_axis.tready) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
